// File: rtl/pixel_pattern_pkg.sv
// Shared types and constants for the pixel pattern writer.
package pixel_pattern_pkg;

  // Width of the internal x/y pixel counters
  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  // RGB565 reference colours
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

endpackage

// File: rtl/pixel_pattern_writer_if.sv
// Avalon-MM write-only bus between the pattern writer and the SRAM controller.
interface pixel_pattern_writer_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [15:0]       avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest
  );
endinterface

// File: rtl/pixel_pattern_gen.sv
// Combinational RGB565 test-pattern generator. Only the coordinate bits the
// patterns actually look at are brought in.
module pixel_pattern_gen
  import pixel_pattern_pkg::*;
(
  input  logic [8:3]  x_i,
  input  logic [7:2]  y_i,
  input  pattern_e    sel_i,
  input  logic [15:0] color_i,
  output logic [15:0] pixel_o
);

  logic [2:0] bar;
  assign bar = x_i[8:6];

  // Select the pixel value for the current coordinate
  always_comb begin
    pixel_o = RGB_BLACK;
    case (sel_i)
      PAT_SOLID: pixel_o = color_i;
      PAT_GRAD:  pixel_o = {x_i[8:4], y_i[7:2], 5'b0};
      PAT_BARS:  pixel_o = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
      PAT_CHECK: pixel_o = (x_i[3] ^ y_i[3]) ? RGB_WHITE : RGB_BLACK;
      default:   pixel_o = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/pixel_pattern_writer.sv
// Avalon-MM write master that fills a frame buffer with an RGB565 test
// pattern in raster order, one pixel per accepted write.
module pixel_pattern_writer
  import pixel_pattern_pkg::*;
#(
  parameter int                WIDTH     = 320,
  parameter int                HEIGHT    = 240,
  parameter int                X_BITS    = 9,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           pattern_sel,
  input  logic [15:0]          color,
  output logic                 busy,
  output logic                 done,
  pixel_pattern_writer_if.master avm
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  pattern_e            sel_q, sel_d;
  logic [15:0]         color_q, color_d;
  logic                abort_pend_q, abort_pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, pix_index;
  logic [15:0]         data_q, data_d;
  logic                load, accept, last_pix, abort_hit;

  // The write request is exactly "in WRITE", so acceptance needs only the stall
  assign accept    = (state_q == WRITE) && !avm.avm_waitrequest;
  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  // An abort seen at any point during a stalled write still ends the fill once it lands
  assign abort_hit = abort || abort_pend_q;

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = WRITE;
      WRITE: if (accept) begin
               if (abort_hit)     state_d = IDLE;
               else if (last_pix) state_d = DONE;
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    avm.avm_write   = 1'b0;
    case (state_q)
      WRITE: begin
        busy          = 1'b1;
        avm.avm_write = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter and pattern-setting next values; load marks edges that register a new pixel
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    sel_d        = sel_q;
    color_d      = color_q;
    abort_pend_d = abort_pend_q;
    load         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        sel_d        = pattern_e'(pattern_sel);
        color_d      = color;
        x_d          = '0;
        y_d          = '0;
        abort_pend_d = 1'b0;
        load         = 1'b1;
      end
      WRITE: begin
        if (abort) abort_pend_d = 1'b1;
        if (accept) begin
          load = 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // X/Y address: y selects a 2**X_BITS-pixel row, two bytes per pixel
  assign pix_index = (ADDR_W'(y_d) << X_BITS) + ADDR_W'(x_d);
  assign addr_d    = BASE_ADDR + (pix_index << 1);

  pixel_pattern_gen u_gen (
    .x_i     (x_d[8:3]),
    .y_i     (y_d[7:2]),
    .sel_i   (sel_d),
    .color_i (color_d),
    .pixel_o (data_d)
  );

  // Datapath registers; address/data only move when a new pixel is loaded
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      sel_q        <= PAT_SOLID;
      color_q      <= '0;
      abort_pend_q <= 1'b0;
      addr_q       <= BASE_ADDR;
      data_q       <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      sel_q        <= sel_d;
      color_q      <= color_d;
      abort_pend_q <= abort_pend_d;
      if (load) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end
    end
  end

  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = data_q;
  assign avm.avm_byteenable = 2'b11;

endmodule

// File: tb/tb_pixel_pattern_writer.sv
// Directed bench: full-size solid and bars fills, a 16x16 checker/gradient
// instance and a 4x2 instance for stall, abort, start-ignore and reset.
module tb_pixel_pattern_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: 320x240 defaults ----------------
  logic start_a, abort_a, busy_a, done_a;
  logic [1:0]  sel_a;
  logic [15:0] color_a;
  pixel_pattern_writer_if #(.ADDR_W(32)) if_a ();
  pixel_pattern_writer #(.WIDTH(320), .HEIGHT(240)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start_a), .abort(abort_a),
    .pattern_sel(sel_a), .color(color_a), .busy(busy_a), .done(done_a), .avm(if_a)
  );

  // ---------------- instance B: 16x16 ----------------
  logic start_b, abort_b, busy_b, done_b;
  logic [1:0]  sel_b;
  logic [15:0] color_b;
  pixel_pattern_writer_if #(.ADDR_W(32)) if_b ();
  pixel_pattern_writer #(.WIDTH(16), .HEIGHT(16)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start_b), .abort(abort_b),
    .pattern_sel(sel_b), .color(color_b), .busy(busy_b), .done(done_b), .avm(if_b)
  );

  // ---------------- instance C: 4x2 ----------------
  logic start_c, abort_c, busy_c, done_c;
  logic [1:0]  sel_c;
  logic [15:0] color_c;
  pixel_pattern_writer_if #(.ADDR_W(32)) if_c ();
  pixel_pattern_writer #(.WIDTH(4), .HEIGHT(2)) dut_c (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start_c), .abort(abort_c),
    .pattern_sel(sel_c), .color(color_c), .busy(busy_c), .done(done_c), .avm(if_c)
  );

  logic [15:0] pix_b  [256];
  logic [31:0] addr_b [256];

  int n_wr, n_done, done_cyc, bad_data, bad_addr, unstable, ex, ey, stall;
  logic [31:0] exp_addr, first_addr, last_addr, ref_addr;
  logic [15:0] ref_data, bars [320];

  // Run one full frame on instance B and capture every write by raster position
  task automatic run_b(input logic [1:0] sel, input logic [15:0] col, output int nw, output int nd);
    int bx, by;
    bx = 0; by = 0; nw = 0; nd = 0;
    sel_b = sel; color_b = col; start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    for (int kk = 0; kk < 16 * 16 + 4; kk++) begin
      if (done_b) nd++;
      if (if_b.avm_write) begin
        if (nw < 256) begin
          pix_b[by * 16 + bx]  = if_b.avm_writedata;
          addr_b[by * 16 + bx] = if_b.avm_address;
        end
        nw++;
        bx++;
        if (bx == 16) begin bx = 0; by++; end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nw, nd;
    rst_n = 1'b1;
    {start_a, abort_a, start_b, abort_b, start_c, abort_c} = '0;
    sel_a = 0; sel_b = 0; sel_c = 0;
    color_a = 0; color_b = 0; color_c = 0;
    if_a.avm_waitrequest = 1'b0;
    if_b.avm_waitrequest = 1'b0;
    if_c.avm_waitrequest = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    // reset state, before any clock edge
    check_val("rst_write",   if_a.avm_write, 0);
    check_val("rst_addr",    if_a.avm_address, 0);
    check_val("rst_data",    if_a.avm_writedata, 0);
    check_val("rst_be",      if_a.avm_byteenable, 2'b11);
    check_val("rst_busy",    busy_a, 0);
    check_val("rst_done",    done_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------- solid fill, full frame ----------
    color_a = 16'hF800; sel_a = 2'd0; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    ex = 0; ey = 0; n_wr = 0; n_done = 0; done_cyc = 0; bad_data = 0; bad_addr = 0;
    first_addr = 32'hFFFF_FFFF; last_addr = 32'hFFFF_FFFF;
    // kk counts edges since the start edge; cycle index kk+1 counts start's cycle as 0
    for (int kk = 0; kk < 320 * 240 + 5; kk++) begin
      if (done_a) begin n_done++; done_cyc = kk + 1; end
      if (if_a.avm_write) begin
        exp_addr = ((ey << 9) + ex) * 2;
        if (if_a.avm_address !== exp_addr) bad_addr++;
        if (if_a.avm_writedata !== 16'hF800) bad_data++;
        if (n_wr == 0) first_addr = if_a.avm_address;
        last_addr = if_a.avm_address;
        n_wr++;
        ex++;
        if (ex == 320) begin ex = 0; ey++; end
      end
      @(negedge clk);
    end
    check_val("solid_writes",     n_wr, 76800);
    check_val("solid_bad_data",   bad_data, 0);
    check_val("solid_bad_addr",   bad_addr, 0);
    check_val("solid_first_addr", first_addr, 32'h0);
    check_val("solid_last_addr",  last_addr, 32'h3BE7E);
    check_val("solid_done_count", n_done, 1);
    check_val("solid_done_cycle", done_cyc, 76801);
    check_val("solid_busy_after", busy_a, 0);

    // ---------- bars, first line then abort ----------
    sel_a = 2'd2; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    ex = 0; n_wr = 0; n_done = 0;
    for (int kk = 0; kk < 330; kk++) begin
      abort_a = 1'b0;
      if (done_a) n_done++;
      if (if_a.avm_write) begin
        if (ex < 320) bars[ex] = if_a.avm_writedata;
        if (ex == 319) abort_a = 1'b1;
        n_wr++;
        ex++;
      end
      @(negedge clk);
    end
    abort_a = 1'b0;
    check_val("bars_x0",     bars[0],   16'h0000);
    check_val("bars_x64",    bars[64],  16'h001F);
    check_val("bars_x128",   bars[128], 16'h07E0);
    check_val("bars_x319",   bars[319], 16'hF800);
    check_val("bars_writes", n_wr, 320);
    check_val("bars_nodone", n_done, 0);
    check_val("bars_busy",   busy_a, 0);

    // ---------- checker and gradient on 16x16 ----------
    run_b(2'd3, 16'h0000, nw, nd);
    check_val("chk_writes",  nw, 256);
    check_val("chk_done",    nd, 1);
    check_val("chk_0_0",     pix_b[0],   16'h0000);
    check_val("chk_8_0",     pix_b[8],   16'hFFFF);
    check_val("chk_8_8",     pix_b[136], 16'h0000);
    check_val("chk_0_15",    pix_b[240], 16'hFFFF);
    check_val("chk_addr_0_1",   addr_b[16],  32'h400);
    check_val("chk_addr_15_15", addr_b[255], 32'h3C1E);
    run_b(2'd1, 16'h0000, nw, nd);
    check_val("grad_0_4",   pix_b[64],  16'h0020);
    check_val("grad_15_8",  pix_b[143], 16'h0040);
    check_val("grad_0_15",  pix_b[240], 16'h0060);

    // ---------- 3 stall cycles per write on 4x2 ----------
    sel_c = 2'd0; color_c = 16'hABCD; start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    ex = 0; ey = 0; n_wr = 0; n_done = 0; done_cyc = 0; bad_data = 0; bad_addr = 0;
    unstable = 0; stall = 0;
    for (int kk = 0; kk < 40; kk++) begin
      if (done_c) begin n_done++; done_cyc = kk + 1; end
      if (if_c.avm_write) begin
        if (stall == 0) begin
          ref_addr = if_c.avm_address;
          ref_data = if_c.avm_writedata;
        end else if (if_c.avm_address !== ref_addr || if_c.avm_writedata !== ref_data) begin
          unstable++;
        end
        if (stall < 3) begin
          if_c.avm_waitrequest = 1'b1;
          stall++;
        end else begin
          if_c.avm_waitrequest = 1'b0;
          stall = 0;
          exp_addr = ((ey << 9) + ex) * 2;
          if (if_c.avm_address !== exp_addr) bad_addr++;
          if (if_c.avm_writedata !== 16'hABCD) bad_data++;
          n_wr++;
          ex++;
          if (ex == 4) begin ex = 0; ey++; end
        end
      end else begin
        if_c.avm_waitrequest = 1'b0;
      end
      @(negedge clk);
    end
    if_c.avm_waitrequest = 1'b0;
    check_val("wait_writes",    n_wr, 8);
    check_val("wait_unstable",  unstable, 0);
    check_val("wait_bad_addr",  bad_addr, 0);
    check_val("wait_bad_data",  bad_data, 0);
    check_val("wait_done_cnt",  n_done, 1);
    check_val("wait_done_cyc",  done_cyc, 33);

    // ---------- abort while stalled ----------
    color_c = 16'h1111; start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    n_wr = 0; n_done = 0;
    if (if_c.avm_write) n_wr++;           // pixel (0,0) accepted immediately
    @(negedge clk);
    if_c.avm_waitrequest = 1'b1; abort_c = 1'b1;
    check_val("abort_pend_addr", if_c.avm_address, 32'h2);
    @(negedge clk);
    check_val("abort_write_held", if_c.avm_write, 1);
    check_val("abort_addr_held",  if_c.avm_address, 32'h2);
    @(negedge clk);
    check_val("abort_write_held2", if_c.avm_write, 1);
    if_c.avm_waitrequest = 1'b0;
    if (if_c.avm_write) n_wr++;
    @(negedge clk);
    abort_c = 1'b0;
    check_val("abort_idle_write", if_c.avm_write, 0);
    check_val("abort_idle_busy",  busy_c, 0);
    for (int kk = 0; kk < 10; kk++) begin
      if (if_c.avm_write) n_wr++;
      if (done_c) n_done++;
      @(negedge clk);
    end
    check_val("abort_writes", n_wr, 2);
    check_val("abort_nodone", n_done, 0);

    // ---------- start mid-fill is ignored ----------
    sel_c = 2'd0; color_c = 16'h5555; start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    n_wr = 0; n_done = 0; bad_data = 0;
    for (int kk = 0; kk < 12; kk++) begin
      start_c = (kk == 2);
      if (kk == 2) begin sel_c = 2'd3; color_c = 16'h0000; end
      if (done_c) n_done++;
      if (if_c.avm_write) begin
        n_wr++;
        if (if_c.avm_writedata !== 16'h5555) bad_data++;
      end
      @(negedge clk);
    end
    start_c = 1'b0;
    check_val("restart_writes",   n_wr, 8);
    check_val("restart_bad_data", bad_data, 0);
    check_val("restart_done",     n_done, 1);

    // ---------- reset mid-fill ----------
    sel_c = 2'd0; color_c = 16'h07E0; start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rstmid_active", if_c.avm_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_write", if_c.avm_write, 0);
    check_val("rstmid_addr",  if_c.avm_address, 32'h0);
    check_val("rstmid_data",  if_c.avm_writedata, 0);
    check_val("rstmid_be",    if_c.avm_byteenable, 2'b11);
    check_val("rstmid_busy",  busy_c, 0);
    check_val("rstmid_done",  done_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rstrel_nowrite", if_c.avm_write, 0);
    start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    check_val("rstrel_write", if_c.avm_write, 1);
    check_val("rstrel_addr",  if_c.avm_address, 32'h0);
    check_val("rstrel_data",  if_c.avm_writedata, 16'h07E0);
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
